// File: rtl/flex_timer_if.sv
// Control/status bundle for flex_timer.
// Optional port wrap_cnt exists only when FLEX_TIMER_WRAP_CNT_EN is defined.
interface flex_timer_if #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_PRE_BITS = 4
);

  logic                    clear;
  logic                    start;
  logic                    stop;
  logic                    oneshot;
  logic                    dir_down;
  logic [NUM_PRE_BITS-1:0] prescale_val;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    busy;
  logic                    done_pulse;
`ifdef FLEX_TIMER_WRAP_CNT_EN
  logic [7:0]              wrap_cnt;
`endif

  // Controller side: drives commands and config, observes status.
  modport master (
    output clear, start, stop, oneshot, dir_down, prescale_val, rollover_val,
`ifdef FLEX_TIMER_WRAP_CNT_EN
    input  wrap_cnt,
`endif
    input  count_out, rollover_flag, busy, done_pulse
  );

  // Timer side.
  modport slave (
    input  clear, start, stop, oneshot, dir_down, prescale_val, rollover_val,
`ifdef FLEX_TIMER_WRAP_CNT_EN
    output wrap_cnt,
`endif
    output count_out, rollover_flag, busy, done_pulse
  );

endinterface

// File: rtl/flex_timer.sv
// flex_timer: programmable prescaled up/down timer with one-shot or periodic
// mode and an IDLE/RUN/DONE state machine. Configuration is latched on start.
// Optional feature macro: FLEX_TIMER_WRAP_CNT_EN adds an 8-bit saturating
// count of periodic terminal-count events on bus.wrap_cnt.
module flex_timer #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_PRE_BITS = 4
) (
  input logic         clk,
  input logic         n_rst,
  flex_timer_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    done_q, done_d;
  logic [NUM_PRE_BITS-1:0] pre_q, pre_d;
  logic [NUM_CNT_BITS-1:0] r_q, r_d;
  logic [NUM_PRE_BITS-1:0] p_q, p_d;
  logic                    oneshot_q, oneshot_d;
  logic                    down_q, down_d;

  // Tick-time helpers derived from latched config only.
  logic                    tick;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic [NUM_CNT_BITS-1:0] count_tick;
  logic                    start_ok;

  // Decode tick, terminal value and the count loaded by a tick.
  always_comb begin
    tick       = (state_q == StRun) && (pre_q == p_q);
    terminal   = down_q ? CntOne : r_q;
    count_tick = count_q;
    if (down_q) begin
      count_tick = (count_q == CntOne) ? r_q : count_q - CntOne;
    end else begin
      count_tick = (count_q == r_q) ? CntOne : count_q + CntOne;
    end
    start_ok = bus.start && (bus.rollover_val != CntZero);
  end

`ifdef FLEX_TIMER_WRAP_CNT_EN
  logic [7:0] wrap_q, wrap_d;

  // Saturating count of periodic-mode terminal-count loads.
  always_comb begin
    wrap_d = wrap_q;
    if (bus.clear) begin
      wrap_d = '0;
    end else if (bus.stop) begin
      wrap_d = wrap_q;
    end else if (start_ok) begin
      wrap_d = '0;
    end else if (tick && !oneshot_q && (count_tick == terminal) && (wrap_q != 8'hff)) begin
      wrap_d = wrap_q + 8'd1;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap_cnt = wrap_q;
`endif

  // Next-state logic; priority clear > stop > start > tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    pre_d     = pre_q;
    r_d       = r_q;
    p_d       = p_q;
    oneshot_d = oneshot_q;
    down_d    = down_q;

    if (bus.clear) begin
      state_d = StIdle;
      count_d = '0;
      flag_d  = 1'b0;
      pre_d   = '0;
    end else if (bus.stop) begin
      state_d = StIdle;
      flag_d  = 1'b0;
      pre_d   = '0;
    end else if (start_ok) begin
      state_d   = StRun;
      r_d       = bus.rollover_val;
      p_d       = bus.prescale_val;
      oneshot_d = bus.oneshot;
      down_d    = bus.dir_down;
      pre_d     = '0;
      count_d   = bus.dir_down ? bus.rollover_val : CntZero;
      flag_d    = bus.dir_down && (bus.rollover_val == CntOne);
    end else if (state_q == StRun) begin
      if (tick) begin
        pre_d   = '0;
        count_d = count_tick;
        flag_d  = (count_tick == terminal);
        if (oneshot_q && (count_tick == terminal)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end else begin
        pre_d = pre_q + NUM_PRE_BITS'(1);
      end
    end
  end

  // State, counter and latched configuration registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      pre_q     <= '0;
      r_q       <= '0;
      p_q       <= '0;
      oneshot_q <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
      done_q    <= done_d;
      pre_q     <= pre_d;
      r_q       <= r_d;
      p_q       <= p_d;
      oneshot_q <= oneshot_d;
      down_q    <= down_d;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.busy          = (state_q == StRun);
  assign bus.done_pulse    = done_q;

endmodule

// File: tb/tb_flex_timer.sv
// Directed self-checking bench for flex_timer.
module tb_flex_timer;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  flex_timer_if #(.NUM_CNT_BITS(8), .NUM_PRE_BITS(4)) bus ();

  flex_timer #(.NUM_CNT_BITS(8), .NUM_PRE_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic status(input string tag, input int cnt, input int flg, input int bsy,
                        input int dne);
    chk({tag, ".count"}, 32'(bus.count_out), 32'(cnt));
    chk({tag, ".flag"}, 32'(bus.rollover_flag), 32'(flg));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".done"}, 32'(bus.done_pulse), 32'(dne));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.oneshot = 1'b0;
    bus.dir_down = 1'b0;
    bus.prescale_val = 4'd0;
    bus.rollover_val = 8'd0;
    #3;
    status("reset", 0, 0, 0, 0);
    steps(2);
    n_rst = 1'b1;
    steps(1);
    status("idle", 0, 0, 0, 0);

    // Up, periodic, R=3, P=0.
    bus.rollover_val = 8'd3;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    status("up0", 0, 0, 1, 0);
    steps(1); status("up1", 1, 0, 1, 0);
    steps(1); status("up2", 2, 0, 1, 0);
    steps(1); status("up3", 3, 1, 1, 0);
    steps(1); status("up1b", 1, 0, 1, 0);
    steps(1); status("up2b", 2, 0, 1, 0);
    steps(1); status("up3b", 3, 1, 1, 0);

    // Down, one-shot, R=4, P=2 (restart from RUN).
    bus.rollover_val = 8'd4;
    bus.prescale_val = 4'd2;
    bus.oneshot = 1'b1;
    bus.dir_down = 1'b1;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    status("dn4", 4, 0, 1, 0);
    steps(2); status("dn4h", 4, 0, 1, 0);
    steps(1); status("dn3", 3, 0, 1, 0);
    steps(2); status("dn3h", 3, 0, 1, 0);
    steps(1); status("dn2", 2, 0, 1, 0);
    steps(3); status("dn1", 1, 1, 0, 1);
    steps(1); status("done1", 1, 1, 0, 0);
    steps(5); status("done2", 1, 1, 0, 0);

    // Clear from DONE, then start with R=0 while IDLE is ignored.
    bus.clear = 1'b1;
    steps(1);
    bus.clear = 1'b0;
    status("clr_done", 0, 0, 0, 0);
    bus.rollover_val = 8'd0;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    status("start_r0", 0, 0, 0, 0);

    // Clear during RUN at count 5.
    bus.rollover_val = 8'd9;
    bus.prescale_val = 4'd0;
    bus.oneshot = 1'b0;
    bus.dir_down = 1'b0;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    steps(5); status("pre_clr", 5, 0, 1, 0);
    bus.clear = 1'b1;
    steps(1);
    bus.clear = 1'b0;
    status("clr_run", 0, 0, 0, 0);

    // Config change mid-run has no effect; start+stop -> stop wins.
    bus.rollover_val = 8'd3;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    bus.rollover_val = 8'd9;
    steps(3); status("latch3", 3, 1, 1, 0);
    steps(1); status("latch1", 1, 0, 1, 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    steps(1);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    status("stopwin", 1, 0, 0, 0);
    steps(2); status("stophold", 1, 0, 0, 0);

    // Async reset mid-run at count 6, checked before the next edge.
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    steps(6); status("pre_rst", 6, 0, 1, 0);
    #2;
    n_rst = 1'b0;
    #1;
    status("async_rst", 0, 0, 0, 0);
    #3;
    n_rst = 1'b1;
    steps(1);

`ifdef FLEX_TIMER_WRAP_CNT_EN
    // Wrap counter: R=2, P=0, periodic; saturates at 255.
    bus.rollover_val = 8'd2;
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    chk("wrap0", 32'(bus.wrap_cnt), 32'd0);
    steps(2);
    chk("wrap1", 32'(bus.wrap_cnt), 32'd1);
    steps(2);
    chk("wrap2", 32'(bus.wrap_cnt), 32'd2);
    steps(600);
    chk("wrap_sat", 32'(bus.wrap_cnt), 32'd255);
    bus.stop = 1'b1;
    steps(1);
    bus.stop = 1'b0;
    chk("wrap_stop", 32'(bus.wrap_cnt), 32'd255);
    bus.start = 1'b1;
    steps(1);
    bus.start = 1'b0;
    chk("wrap_restart", 32'(bus.wrap_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_timer.md
Name: flex_timer

Overview:
- Parametrised successor to the team's flex counter: a programmable timer for peripheral timing (baud ticks, timeouts, frame gaps).
- Adds a prescaler, up/down direction, one-shot or periodic mode, configuration latched at start, and a run/done state machine.
- Sits between control FSMs and datapath blocks that need periodic or single terminal-count events.

Parameters:
- NUM_CNT_BITS, 8, width of main counter, rollover_val and count_out
- NUM_PRE_BITS, 4, width of prescaler and prescale_val

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear, highest priority
- start  input  1  latch config and (re)start counting
- stop  input  1  abort run, return to IDLE
- oneshot  input  1  1 = stop at first terminal count; 0 = periodic
- dir_down  input  1  1 = count down, 0 = count up
- prescale_val  input  NUM_PRE_BITS  tick every prescale_val+1 RUN cycles
- rollover_val  input  NUM_CNT_BITS  terminal/reload value R
- count_out  output  NUM_CNT_BITS  current count
- rollover_flag  output  1  high while count_out equals the terminal value
- busy  output  1  high in RUN
- done_pulse  output  1  one-cycle pulse when a one-shot run completes

Behaviour:
- Reset (n_rst low, async): state IDLE, count_out 0, rollover_flag 0, done_pulse 0, prescaler 0, latched config 0.
- Every output is registered. busy is high exactly when state == RUN.
- States: IDLE, RUN, DONE.
- Input priority, evaluated per cycle: clear > stop > start > tick.
- clear:
  - state IDLE, count_out 0, flag 0, prescaler 0.
  - done_pulse 0.
- stop:
  - state IDLE, prescaler 0, flag 0.
  - count_out holds.
- start, from any state:
  - If rollover_val == 0: ignored, state unchanged.
  - Otherwise latch R, P (prescale_val), oneshot and dir_down; prescaler 0; state RUN.
  - count_out loads 0 (up) or R (down). rollover_flag loads 1 if down and R == 1, else 0.
  - Input changes during RUN have no effect until the next start.
- Prescaler: runs only in RUN, counts 0..P. A tick occurs in a cycle where prescaler == P; the prescaler then wraps to 0. P = 0 gives a tick every RUN cycle.
- Up count on tick:
  - If count_out == R, next count is 1; otherwise count_out + 1.
  - Sequence after start: 0, 1, ..., R, 1, ..., R.
  - Terminal value is R.
- Down count on tick:
  - If count_out == 1, next count is R; otherwise count_out - 1.
  - Sequence: R, R-1, ..., 1, R, ...
  - Terminal value is 1.
- rollover_flag: updated on the same edge as count_out; high exactly while count_out == terminal and the state is RUN or DONE.
- Periodic mode: remains in RUN indefinitely.
- One-shot mode, on the tick that loads the terminal value:
  - State goes to DONE and done_pulse is high for exactly that one cycle.
  - In DONE, count_out and flag hold, and the prescaler is idle.
  - Only start, stop or clear leave DONE.
- Latency: with P = 0, start sampled at edge k gives count 0 at k, 1 at k+1, ..., R at k+R (up). Each tick spans P+1 cycles.
- Simultaneous start and tick: start wins (reload). Simultaneous stop and start: stop wins.
- Reset asserted mid-run: immediate return to reset values.

Optional Feature:
- Macro FLEX_TIMER_WRAP_CNT_EN.
- Defined:
  - Adds output port wrap_cnt (8 bits).
  - Increments on every periodic-mode tick that loads the terminal value, saturating at 255.
  - Cleared by reset, clear and start; held by stop.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Up, periodic, R=3, P=0, start one cycle -> count_out 0,1,2,3,1,2,3 on successive cycles; flag high only when 3; busy 1; done_pulse never.
- Down, one-shot, R=4, P=2 -> count_out 4, then 3, 2, 1 each after 3 cycles; done_pulse a single cycle with count 1; state DONE; count and flag hold 1/1; busy 0.
- start with rollover_val=0 while IDLE -> no change (busy 0, count 0). clear during RUN at count 5 -> next cycle count 0, flag 0, busy 0.
- Change rollover_val from 3 to 9 mid-run (up, R=3) -> still wraps after 3. Assert start and stop together -> stop wins: IDLE, count held.
- Async n_rst pulse mid-run with count 6 -> outputs 0 immediately, without waiting for clk. With FLEX_TIMER_WRAP_CNT_EN: R=2, P=0, 600 cycles periodic -> wrap_cnt saturates at 255.
